mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the memory's second read port (raddr1/rdata1) and its write port (wen/waddr/wdata)
//   between two requesters: the CPU load/store path (CPU) and a secondary master (SEC, e.g. loader/debug).
//   At most one access is granted per cycle. Read data returns RD_LAT cycles after grant, tagged back to its owner.
//   CPU has priority. A starvation counter guarantees SEC progress. SEC may lock the port for atomic sequences.
// PARAMETERS
//   ADDR_W      15  word address width (byte address bits [15:1])
//   DATA_W      16  data width
//   RD_LAT      2   memory read latency in cycles, grant to rdata valid (>=1)
//   STARVE_MAX  4   consecutive denied SEC-request cycles before SEC wins arbitration (>=1)
// PORTS
//   clk         in   1       clock, all state updates on posedge
//   rst_n       in   1       synchronous reset, active low
//   cpu_req     in   1       CPU access request
//   cpu_we      in   1       1 = write, 0 = read
//   cpu_addr    in   ADDR_W  CPU word address
//   cpu_wdata   in   DATA_W  CPU write data
//   cpu_gnt     out  1       CPU access accepted this cycle (combinational)
//   cpu_rvalid  out  1       CPU read data valid
//   cpu_rdata   out  DATA_W  CPU read data
//   sec_req     in   1       SEC access request
//   sec_we      in   1       1 = write, 0 = read
//   sec_addr    in   ADDR_W  SEC word address
//   sec_wdata   in   DATA_W  SEC write data
//   sec_lock    in   1       sampled with sec_gnt: 1 = hold port for further SEC beats
//   sec_gnt     out  1       SEC access accepted this cycle (combinational)
//   sec_rvalid  out  1       SEC read data valid
//   sec_rdata   out  DATA_W  SEC read data
//   mem_raddr   out  ADDR_W  to mem read port 1
//   mem_rdata   in   DATA_W  from mem read port 1
//   mem_wen     out  1       mem write enable
//   mem_waddr   out  ADDR_W  mem write address
//   mem_wdata   out  DATA_W  mem write data
// BEHAVIOUR
//   - Clock/reset: single clock clk; reset rst_n is synchronous, active low.
//   - Reset: state=ARB, starve=0, read-tag pipeline cleared, so in-flight reads are dropped and no rvalid is raised for them.
//     During reset, cpu_gnt/sec_gnt/mem_wen/*_rvalid are 0 and *_rdata/mem_* addresses/data are 0.
//   - Handshake: an access happens when req & gnt. A requester holds req/we/addr/wdata stable until granted.
//     gnt is never raised without req. cpu_gnt & sec_gnt is never 1.
//   - State ARB:
//       sec_gnt = sec_req & (~cpu_req | starve==STARVE_MAX); otherwise cpu_gnt = cpu_req.
//   - starve: +1 per cycle with sec_req & ~sec_gnt, saturating at STARVE_MAX; cleared to 0 on sec_gnt.
//   - Lock: sec_gnt with sec_lock=1 -> next state LOCKED.
//       In LOCKED, cpu_gnt=0 and sec_gnt=sec_req.
//       A sec_gnt with sec_lock=0 -> ARB next cycle.
//       A LOCKED cycle with sec_req=0 stays LOCKED (no timeout). Only reset exits LOCKED otherwise.
//   - Mem drive (combinational from the winner):
//       write grant -> mem_wen=1, mem_waddr=addr, mem_wdata=wdata.
//       read grant  -> mem_raddr=addr, mem_wen=0.
//       no grant    -> mem_wen=0, mem_raddr/mem_waddr/mem_wdata=0.
//   - Write completion: a write completes in its grant cycle and produces no rvalid.
//   - Read return: each read grant pushes {valid=1, owner} into an RD_LAT-deep shift pipeline.
//       At the tail, the owner's rvalid=1 and rdata=mem_rdata for that cycle only.
//       The non-owner rvalid=0 and its rdata=0. Back-to-back reads return back-to-back, in grant order.
//   - Ordering: a write granted after a read to the same address does not affect that read's data.
//     This follows from mem semantics; the arbiter does no forwarding.
// TESTING
//   - Reset mid-LOCKED with 2 reads in flight: rst_n=0 for 1 cycle -> state ARB.
//     No rvalid on either port for those reads. cpu_req then granted same cycle.
//   - CPU-only read addr 0x0010, mem returns 0xBEEF: cpu_gnt same cycle.
//     cpu_rvalid=1 with cpu_rdata=0xBEEF exactly 2 cycles later. sec_rvalid stays 0.
//   - Both request continuously (CPU reads, SEC writes 0x1234 to 0x0020), STARVE_MAX=4:
//     cpu_gnt cycles 0-3, sec_gnt cycle 4 with mem_wen=1, mem_waddr=0x0020, mem_wdata=0x1234. Pattern repeats every 5 cycles.
//   - SEC read 0x0030 with lock=1, then write 0x0030 with lock=0, CPU requesting throughout:
//     cpu_gnt=0 for both beats. CPU granted the cycle after the unlock beat.
//   - Interleaved grants CPU-rd, SEC-rd, CPU-rd on consecutive cycles:
//     rvalid returns cpu, sec, cpu on cycles +2, +3, +4, each with its own mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates memory read port 1 and the write port between two requesters.
//   CPU is the load/store path. SEC is a secondary master, such as a loader or debug unit.
//   At most one access is granted per cycle, and CPU normally wins.
//   A starvation counter lets SEC win after STARVE_MAX consecutive denied cycles.
//   SEC can lock the port to issue atomic multi-beat sequences.
//   Read data returns RD_LAT cycles after the grant and is steered back to the requester that issued the read.
//
// Ports
//   clk, rst_n                                   clock, synchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt             CPU request, combinational grant
//   cpu_rvalid/cpu_rdata                         CPU read return
//   sec_req/we/addr/wdata/lock -> sec_gnt        SEC request, combinational grant
//   sec_rvalid/sec_rdata                         SEC read return
//   mem_raddr, mem_rdata                         memory read port 1
//   mem_wen/mem_waddr/mem_wdata                  memory write port
module mem_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              sec_req,
    input  logic              sec_we,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [DATA_W-1:0] sec_wdata,
    input  logic              sec_lock,
    output logic              sec_gnt,
    output logic              sec_rvalid,
    output logic [DATA_W-1:0] sec_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t            state;
    logic [SW-1:0]     starve;
    // Read-return tag pipeline; index 0 is loaded on the grant edge.
    // own_p = 1 marks a SEC-owned read.
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] own_p;
    logic              rd_gnt;
    logic              tail_vld;

    // Grant decision. Grants are forced low while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        sec_gnt = 1'b0;
        if (rst_n) begin
            if (state == LOCKED) begin
                sec_gnt = sec_req;
            end else begin
                sec_gnt = sec_req & (~cpu_req | (starve == STARVE_LIM));
                cpu_gnt = cpu_req & ~sec_gnt;
            end
        end
    end

    // Drive the memory from the winner. Idle cycles drive zeros.
    always_comb begin
        mem_wen   = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            if (cpu_we) begin
                mem_wen   = 1'b1;
                mem_waddr = cpu_addr;
                mem_wdata = cpu_wdata;
            end else begin
                mem_raddr = cpu_addr;
            end
        end else if (sec_gnt) begin
            if (sec_we) begin
                mem_wen   = 1'b1;
                mem_waddr = sec_addr;
                mem_wdata = sec_wdata;
            end else begin
                mem_raddr = sec_addr;
            end
        end
    end

    assign rd_gnt = (cpu_gnt & ~cpu_we) | (sec_gnt & ~sec_we);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ARB;
            starve <= '0;
            vld_p  <= '0;
            own_p  <= '0;
        end else begin
            // A locked beat keeps the port; an unlocked beat releases it.
            // With no SEC beat, the state holds, so LOCKED has no timeout.
            if (sec_gnt) begin
                state <= sec_lock ? LOCKED : ARB;
            end
            if (sec_gnt) begin
                starve <= '0;
            end else if (sec_req && (starve != STARVE_LIM)) begin
                starve <= starve + SW'(1);
            end
            // Tag stage boundary: shift read tags toward the return point.
            vld_p[0] <= rd_gnt;
            own_p[0] <= sec_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                own_p[i] <= own_p[i-1];
            end
        end
    end

    // Return stage: steer the memory data to the owner of the tail tag.
    assign tail_vld   = rst_n & vld_p[RD_LAT-1];
    assign cpu_rvalid = tail_vld & ~own_p[RD_LAT-1];
    assign sec_rvalid = tail_vld &  own_p[RD_LAT-1];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign sec_rdata  = sec_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              sec_req, sec_we, sec_lock;
    logic [ADDR_W-1:0] sec_addr;
    logic [DATA_W-1:0] sec_wdata;
    logic              sec_gnt, sec_rvalid;
    logic [DATA_W-1:0] sec_rdata;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [DATA_W-1:0] mem_rdata, mem_wdata;
    logic              mem_wen;

    int n_assert = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_lock(sec_lock), .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Inputs change 2 time units after posedge,
    // and checks run 1 time unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cpu_req = 1'b0; sec_req = 1'b0; cpu_we = 1'b0; sec_we = 1'b0; sec_lock = 1'b0;
        cpu_addr = '0; sec_addr = '0; cpu_wdata = '0; sec_wdata = '0; mem_rdata = '0;
    endtask

    initial begin
        // Reset with both requesters active: everything must stay quiet.
        idle();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0001; cpu_wdata = 16'hAAAA;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 15'h0002;
        step(); #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_sec_gnt", sec_gnt, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_sec_rvalid", sec_rvalid, 0);
        step();
        rst_n = 1'b1; idle();

        // CPU-only read of 0x0010 that returns 0xBEEF two cycles later.
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010; #1;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_sec_gnt", sec_gnt, 0);
        chk("rd_mem_raddr", mem_raddr, 15'h0010);
        chk("rd_mem_wen", mem_wen, 0);
        step();
        idle(); #1;
        chk("rd_rvalid_early", cpu_rvalid, 0);
        chk("rd_no_gnt_raddr", mem_raddr, 0);
        step();
        mem_rdata = 16'hBEEF; #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("rd_sec_rvalid", sec_rvalid, 0);
        chk("rd_sec_rdata", sec_rdata, 0);
        step();
        mem_rdata = '0; #1;
        chk("rd_rvalid_once", cpu_rvalid, 0);

        // Starvation: the CPU reads continuously while SEC writes 0x1234 to 0x0020.
        for (int c = 0; c < 10; c++) begin
            step();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0044;
            sec_req = 1'b1; sec_we = 1'b1; sec_addr = 15'h0020; sec_wdata = 16'h1234; #1;
            if ((c % 5) == 4) begin
                chk("stv_sec_gnt", sec_gnt, 1);
                chk("stv_cpu_gnt_off", cpu_gnt, 0);
                chk("stv_mem_wen", mem_wen, 1);
                chk("stv_mem_waddr", mem_waddr, 15'h0020);
                chk("stv_mem_wdata", mem_wdata, 16'h1234);
            end else begin
                chk("stv_cpu_gnt", cpu_gnt, 1);
                chk("stv_sec_gnt_off", sec_gnt, 0);
                chk("stv_mem_wen_off", mem_wen, 0);
                chk("stv_mem_raddr", mem_raddr, 15'h0044);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(); idle();
        end

        // Locked sequence: SEC reads 0x0030 with lock, idles once, then writes 0x0030 and unlocks.
        for (int c = 0; c < 5; c++) begin
            step();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0050;
            sec_req = 1'b1; sec_we = 1'b0; sec_addr = 15'h0030; sec_lock = 1'b1; #1;
            if (c == 4) begin
                chk("lk_sec_gnt_rd", sec_gnt, 1);
                chk("lk_cpu_gnt_rd", cpu_gnt, 0);
                chk("lk_mem_raddr", mem_raddr, 15'h0030);
            end else begin
                chk("lk_pre_cpu_gnt", cpu_gnt, 1);
            end
        end
        step();
        sec_req = 1'b0; #1;
        chk("lk_idle_cpu_gnt", cpu_gnt, 0);
        chk("lk_idle_sec_gnt", sec_gnt, 0);
        step();
        sec_req = 1'b1; sec_we = 1'b1; sec_wdata = 16'hCAFE; sec_lock = 1'b0;
        mem_rdata = 16'h5A5A; #1;
        chk("lk_sec_gnt_wr", sec_gnt, 1);
        chk("lk_cpu_gnt_wr", cpu_gnt, 0);
        chk("lk_mem_wen", mem_wen, 1);
        chk("lk_mem_waddr", mem_waddr, 15'h0030);
        chk("lk_mem_wdata", mem_wdata, 16'hCAFE);
        chk("lk_sec_rvalid", sec_rvalid, 1);
        chk("lk_sec_rdata", sec_rdata, 16'h5A5A);
        chk("lk_cpu_rvalid", cpu_rvalid, 0);
        step();
        sec_req = 1'b0; sec_we = 1'b0; mem_rdata = '0; #1;
        chk("lk_unlock_cpu_gnt", cpu_gnt, 1);
        for (int c = 0; c < 3; c++) begin
            step(); idle();
        end

        // Interleaved reads on consecutive cycles: CPU, then SEC, then CPU.
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100; #1;
        chk("il_cpu_gnt0", cpu_gnt, 1);
        step();
        cpu_req = 1'b0; sec_req = 1'b1; sec_we = 1'b0; sec_addr = 15'h0200; #1;
        chk("il_sec_gnt1", sec_gnt, 1);
        chk("il_mem_raddr1", mem_raddr, 15'h0200);
        step();
        sec_req = 1'b0; cpu_req = 1'b1; cpu_addr = 15'h0300; mem_rdata = 16'h1111; #1;
        chk("il_cpu_gnt2", cpu_gnt, 1);
        chk("il_ret0_cpu_rvalid", cpu_rvalid, 1);
        chk("il_ret0_cpu_rdata", cpu_rdata, 16'h1111);
        chk("il_ret0_sec_rvalid", sec_rvalid, 0);
        step();
        cpu_req = 1'b0; mem_rdata = 16'h2222; #1;
        chk("il_ret1_sec_rvalid", sec_rvalid, 1);
        chk("il_ret1_sec_rdata", sec_rdata, 16'h2222);
        chk("il_ret1_cpu_rvalid", cpu_rvalid, 0);
        chk("il_ret1_cpu_rdata", cpu_rdata, 0);
        step();
        mem_rdata = 16'h3333; #1;
        chk("il_ret2_cpu_rvalid", cpu_rvalid, 1);
        chk("il_ret2_cpu_rdata", cpu_rdata, 16'h3333);
        chk("il_ret2_sec_rvalid", sec_rvalid, 0);
        step(); idle(); step();

        // Reset while LOCKED with two SEC reads in flight.
        step();
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 15'h0060; sec_lock = 1'b1; #1;
        chk("rl_sec_gnt0", sec_gnt, 1);
        step();
        sec_addr = 15'h0061; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0070; #1;
        chk("rl_sec_gnt1", sec_gnt, 1);
        chk("rl_cpu_blocked", cpu_gnt, 0);
        step();
        rst_n = 1'b0; sec_req = 1'b0; mem_rdata = 16'h7777; #1;
        chk("rl_rst_sec_rvalid", sec_rvalid, 0);
        chk("rl_rst_sec_rdata", sec_rdata, 0);
        chk("rl_rst_cpu_gnt", cpu_gnt, 0);
        step();
        rst_n = 1'b1; #1;
        chk("rl_post_cpu_gnt", cpu_gnt, 1);
        chk("rl_post_sec_rvalid", sec_rvalid, 0);
        chk("rl_post_cpu_rvalid", cpu_rvalid, 0);
        step();
        cpu_req = 1'b0; #1;
        chk("rl_post2_sec_rvalid", sec_rvalid, 0);
        chk("rl_post2_cpu_rvalid", cpu_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
